// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache. It sits between the fetch unit and
// the memory controller's icache port and allows one outstanding request at a time.
module inst_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        fetch_req_in,
  input  logic [31:0] fetch_addr_in,
  output logic        ready_out,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic        mem_r_nw_out,
  output logic [2:0]  mem_type_out,
  output logic        mem_activate_out,
  input  logic [31:0] mem_data_in,
  input  logic        mem_avail_in,
  input  logic [1:0]  mem_src_in
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, CMP, FILL} state_t;

  state_t                  state, state_nxt;
  logic [31:0]             addr;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tags [LINES];
  logic [31:0]             data [LINES];
  logic                    abort;
  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_W-1:0]        tag;
  logic                    hit, done;

  assign idx  = addr[INDEX_BITS+1:2];
  assign tag  = addr[31:INDEX_BITS+2];
  assign hit  = valid[idx] && (tags[idx] == tag);
  assign done = mem_avail_in && (mem_src_in == 2'b10);

  always_ff @(posedge clk_in) begin
    if (rst_in)      state <= IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_req_in && !clear_in) state_nxt = CMP;
      CMP:     state_nxt = (clear_in || hit) ? IDLE : FILL;
      FILL:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_out    = (state == IDLE);
    mem_data_out = 32'h0;
    mem_r_nw_out = 1'b1;
    mem_type_out = 3'b000;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid            <= '0;
      addr             <= '0;
      abort            <= 1'b0;
      inst_valid_out   <= 1'b0;
      inst_out         <= '0;
      mem_activate_out <= 1'b0;
      mem_addr_out     <= '0;
    end else if (rdy_in) begin
      inst_valid_out <= 1'b0;
      case (state)
        IDLE: if (fetch_req_in && !clear_in) addr <= {fetch_addr_in[31:2], 2'b00};
        CMP: begin
          if (!clear_in) begin
            if (hit) begin
              inst_out       <= data[idx];
              inst_valid_out <= 1'b1;
            end else begin
              mem_addr_out     <= addr;
              mem_activate_out <= 1'b1;
            end
          end
        end
        FILL: begin
          // The controller has already latched the read, so a flush only suppresses the pulse.
          if (done) begin
            valid[idx]       <= 1'b1;
            mem_activate_out <= 1'b0;
            inst_out         <= mem_data_in;
            inst_valid_out   <= !(abort || clear_in);
            abort            <= 1'b0;
          end else if (clear_in) begin
            abort <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && state == FILL && done) begin
      tags[idx] <= tag;
      data[idx] <= mem_data_in;
    end
  end
endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a hand-driven controller port, with expected values
// worked out by hand for each vector.
module tb_inst_cache;
  logic        clk = 1'b0;
  logic        rst, rdy, clear, req;
  logic [31:0] faddr;
  logic        ready, ivalid;
  logic [31:0] inst, maddr, mdata_o;
  logic        r_nw;
  logic [2:0]  mtype;
  logic        mact;
  logic [31:0] mdata;
  logic        mavail;
  logic [1:0]  msrc;

  int checks = 0;
  int errors = 0;

  inst_cache #(.INDEX_BITS(6)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clear),
    .fetch_req_in(req), .fetch_addr_in(faddr),
    .ready_out(ready), .inst_valid_out(ivalid), .inst_out(inst),
    .mem_addr_out(maddr), .mem_data_out(mdata_o), .mem_r_nw_out(r_nw),
    .mem_type_out(mtype), .mem_activate_out(mact),
    .mem_data_in(mdata), .mem_avail_in(mavail), .mem_src_in(msrc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; on return the accept edge has passed (state CMP).
  task automatic fetch(input logic [31:0] a);
    req = 1'b1; faddr = a;
    tick();
    req = 1'b0;
    chk("accept_ready", ready, 0);
  endtask

  task automatic do_hit(input logic [31:0] a, input logic [31:0] exp);
    fetch(a);
    tick();
    chk("hit_valid", ivalid, 1);
    chk("hit_inst", inst, exp);
    chk("hit_noact", mact, 0);
    tick();
    chk("hit_pulse_end", ivalid, 0);
  endtask

  task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input bit lsb, input bit flush);
    fetch(a);
    tick();
    chk("miss_act", mact, 1);
    chk("miss_addr", maddr, {a[31:2], 2'b00});
    chk("miss_novalid", ivalid, 0);
    tick();
    if (flush) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
    end
    if (lsb) begin
      mavail = 1'b1; msrc = 2'b01; mdata = 32'hDEAD_BEEF;
      tick();
      mavail = 1'b0; msrc = 2'b00;
      chk("lsb_ignored_valid", ivalid, 0);
      chk("lsb_ignored_act", mact, 1);
    end
    repeat (2) tick();
    chk("fill_hold_act", mact, 1);
    chk("fill_hold_addr", maddr, {a[31:2], 2'b00});
    mavail = 1'b1; msrc = 2'b10; mdata = d;
    tick();
    mavail = 1'b0; msrc = 2'b00; mdata = 32'h0;
    chk("fill_valid", ivalid, flush ? 0 : 1);
    chk("fill_inst", inst, d);
    chk("fill_act_drop", mact, 0);
    chk("fill_ready", ready, 1);
    tick();
    chk("fill_pulse_end", ivalid, 0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; req = 1'b0; faddr = '0;
    mdata = '0; mavail = 1'b0; msrc = 2'b00;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_valid", ivalid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_act", mact, 0);
    chk("rst_maddr", maddr, 0);
    chk("const_data", mdata_o, 0);
    chk("const_rnw", r_nw, 1);
    chk("const_type", mtype, 0);

    // cold miss then hit, low address bits ignored
    do_miss(32'h0000_0010, 32'h0010_0093, 0, 0);
    do_hit(32'h0000_0010, 32'h0010_0093);
    do_hit(32'h0000_0013, 32'h0010_0093);

    // 0x110 shares index 4 with 0x10
    do_miss(32'h0000_0110, 32'h1111_2222, 0, 0);
    do_miss(32'h0000_0010, 32'h0010_0093, 0, 0);
    do_hit(32'h0000_0010, 32'h0010_0093);

    // LSB completion interleaved during the fill
    do_miss(32'h0000_0200, 32'hCAFE_0001, 1, 0);
    do_hit(32'h0000_0200, 32'hCAFE_0001);

    // flush during fill: no pulse, line still installed
    do_miss(32'h0000_0304, 32'h0BAD_F00D, 0, 1);
    do_hit(32'h0000_0304, 32'h0BAD_F00D);

    // clear beats a same-cycle request in IDLE
    req = 1'b1; faddr = 32'h10; clear = 1'b1;
    tick();
    req = 1'b0; clear = 1'b0;
    chk("idle_clear_ready", ready, 1);

    // clear in CMP: no pulse, no memory request
    fetch(32'h0000_0500);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cmp_clear_valid", ivalid, 0);
    chk("cmp_clear_act", mact, 0);
    chk("cmp_clear_ready", ready, 1);

    // freeze for 3 cycles in CMP, then resume to a hit; freeze holds the pulse
    fetch(32'h0000_0010);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_cmp_valid", ivalid, 0);
      chk("frz_cmp_ready", ready, 0);
    end
    rdy = 1'b1;
    tick();
    chk("frz_resume_valid", ivalid, 1);
    chk("frz_resume_inst", inst, 32'h0010_0093);
    rdy = 1'b0;
    tick();
    chk("frz_pulse_hold", ivalid, 1);
    rdy = 1'b1;
    tick();
    chk("frz_pulse_end", ivalid, 0);

    // freeze in FILL ignores a completion; then reset mid-fill
    fetch(32'h0000_0400);
    tick();
    chk("rf_act", mact, 1);
    rdy = 1'b0; mavail = 1'b1; msrc = 2'b10; mdata = 32'h7777_7777;
    tick();
    mavail = 1'b0; msrc = 2'b00;
    rdy = 1'b1;
    chk("frz_fill_valid", ivalid, 0);
    chk("frz_fill_act", mact, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_fill_act", mact, 0);
    chk("rst_fill_ready", ready, 1);
    chk("rst_fill_maddr", maddr, 0);

    // valid bits cleared: 0x10 misses again, 0x400 not installed either
    do_miss(32'h0000_0010, 32'h0010_0093, 0, 0);
    do_miss(32'h0000_0400, 32'h4444_0000, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
